// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: serial sync-hunting config loader with CRC-8 checked atomic commit
module fpga_cfg_loader #(
  parameter int                   CFG_BITS  = 86,
  parameter logic [7:0]           SYNC_WORD = 8'hA5,
  parameter logic [CFG_BITS-1:0]  CFG_RESET = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_in,
  input  logic                bit_valid,
  output logic                bit_ready,
  input  logic                abort,
  output logic [CFG_BITS-1:0] cfg_out,
  output logic                cfg_commit,
  output logic                cfg_loaded,
  output logic                crc_err,
  output logic                busy
);
  localparam int CW = $clog2(CFG_BITS+1);
  typedef enum logic [1:0] {HUNT, LOAD, RCRC, CHECK} state_t;
  state_t r_state, w_nxt;
  logic [7:0] r_win, r_crc, r_rx;
  logic [CFG_BITS-1:0] r_sh;
  logic [CW-1:0] r_cnt;
  logic w_acc, w_fb, w_good, w_last_pay, w_last_crc;
  logic [7:0] w_win, w_crc;
  assign w_acc      = bit_valid && bit_ready;
  assign w_win      = {r_win[6:0], bit_in};
  assign w_fb       = r_crc[7] ^ bit_in;
  assign w_crc      = {r_crc[6:0], 1'b0} ^ (w_fb ? 8'h07 : 8'h00);
  assign w_good     = r_crc == r_rx;
  assign w_last_pay = r_cnt == CW'(CFG_BITS-1);
  assign w_last_crc = r_cnt == CW'(7);
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? HUNT : w_nxt;
  // next state: only accepted bits advance, CHECK always lasts one cycle, abort wins
  always_comb
    w_nxt = abort                                    ? HUNT  :
            r_state == CHECK                         ? HUNT  :
            !w_acc                                   ? r_state :
            (r_state == HUNT && w_win == SYNC_WORD)  ? LOAD  :
            (r_state == LOAD && w_last_pay)          ? RCRC  :
            (r_state == RCRC && w_last_crc)          ? CHECK : r_state;
  // handshake, status and one-cycle verdict pulses
  always_comb begin
    bit_ready  = r_state != CHECK;
    busy       = r_state != HUNT;
    cfg_commit = r_state == CHECK && !abort && w_good;
    crc_err    = r_state == CHECK && !abort && !w_good;
  end
  // sync window, payload shadow, running CRC, received CRC, bit counter and committed word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win      <= '0;
      r_sh       <= '0;
      r_crc      <= '0;
      r_rx       <= '0;
      r_cnt      <= '0;
      cfg_out    <= CFG_RESET;
      cfg_loaded <= 1'b0;
    end else begin
      r_win <= (abort || w_nxt != HUNT) ? '0 : (w_acc && r_state == HUNT) ? w_win : r_win;
      r_cnt <= (abort || w_nxt != r_state) ? '0 : (w_acc && r_state != HUNT) ? r_cnt + 1'b1 : r_cnt;
      r_sh  <= abort ? '0 : (w_acc && r_state == LOAD) ? {r_sh[CFG_BITS-2:0], bit_in} : r_sh;
      r_crc <= (abort || (r_state == HUNT && w_nxt == LOAD)) ? '0 : (w_acc && r_state == LOAD) ? w_crc : r_crc;
      r_rx  <= (!abort && w_acc && r_state == RCRC) ? {r_rx[6:0], bit_in} : r_rx;
      if (cfg_commit) begin
        cfg_out    <= r_sh;
        cfg_loaded <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader: randomized frames checked each cycle against a bit-queue model with division-based CRC
module tb_fpga_cfg_loader;
  localparam int N = 86;
  logic clk = 0, rst = 1, bit_in = 0, bit_valid = 0, abort = 0;
  logic bit_ready, cfg_commit, cfg_loaded, crc_err, busy;
  logic [N-1:0] cfg_out;
  int total = 0, bad = 0, n_com = 0, n_err = 0, n_nr = 0;
  logic on = 0;
  logic m_frame = 0, m_chk = 0, m_loaded = 0;
  logic [7:0] m_win = 0, m_rx = 0;
  logic [N-1:0] m_pay = 0, m_cfg = 0;
  int m_n = 0, m_rn = 0;

  fpga_cfg_loader dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .abort(abort), .cfg_out(cfg_out), .cfg_commit(cfg_commit), .cfg_loaded(cfg_loaded),
    .crc_err(crc_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // CRC as remainder of (message * x^8) modulo x^8+x^2+x+1
  function automatic logic [7:0] crc8(input logic [127:0] v, input int n);
    logic [135:0] a;
    a = {v, 8'h00};
    for (int i = n + 7; i >= 8; i--)
      if (a[i]) a[i -: 9] = a[i -: 9] ^ 9'h107;
    return a[7:0];
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_frame = 0; m_chk = 0; m_win = 0; m_n = 0; m_rn = 0; m_cfg = 0; m_loaded = 0;
    end else if (abort) begin
      m_frame = 0; m_chk = 0; m_win = 0; m_n = 0; m_rn = 0;
    end else if (m_chk) begin
      if (crc8(m_pay, N) == m_rx) begin m_cfg = m_pay; m_loaded = 1; end
      m_chk = 0; m_frame = 0; m_n = 0; m_rn = 0;
    end else if (bit_valid) begin
      if (!m_frame) begin
        m_win = {m_win[6:0], bit_in};
        if (m_win == 8'hA5) begin m_frame = 1; m_win = 0; m_n = 0; m_rn = 0; end
      end else if (m_n < N) begin
        m_pay = {m_pay[N-2:0], bit_in}; m_n++;
      end else begin
        m_rx = {m_rx[6:0], bit_in}; m_rn++;
        if (m_rn == 8) m_chk = 1;
      end
    end
  end

  initial forever begin
    logic good;
    @(negedge clk);
    if (on) begin
      good = crc8(m_pay, N) == m_rx;
      chk("bit_ready", bit_ready, !m_chk);
      chk("busy", busy, m_frame);
      chk("cfg_commit", cfg_commit, m_chk && !abort && good);
      chk("crc_err", crc_err, m_chk && !abort && !good);
      chk("cfg_out", cfg_out, m_cfg);
      chk("cfg_loaded", cfg_loaded, m_loaded);
      n_com += int'(cfg_commit);
      n_err += int'(crc_err);
      n_nr  += int'(!bit_ready);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic b, input logic rnd);
    int t;
    t = 0;
    if (rnd) repeat ($urandom_range(0, 2)) begin bit_valid = 0; bit_in = 1'($urandom); cyc(); end
    bit_valid = 1; bit_in = b;
    @(negedge clk);
    while (!bit_ready && t < 5) begin t++; @(negedge clk); end
    total++;
    if (t >= 5) begin bad++; $display("FAIL ready_timeout: got bit_ready=0 want 1 within 5 cycles"); end
    @(posedge clk); #1;
    bit_valid = 0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic rnd);
    for (int i = 7; i >= 0; i--) send(v[i], rnd);
  endtask

  task automatic frame(input logic [N-1:0] p, input logic flip, input int cut, input logic cut_rst, input logic rnd);
    logic [7:0] c;
    c = crc8(p, N) ^ {7'b0, flip};
    send_byte(8'hA5, rnd);
    for (int i = 0; i < N; i++) begin
      if (i == cut) begin
        if (cut_rst) rst = 1; else abort = 1;
        bit_valid = 1; bit_in = p[N-1-i];
        cyc();
        rst = 0; abort = 0; bit_valid = 0;
        return;
      end
      send(p[N-1-i], rnd);
    end
    send_byte(c, rnd);
  endtask

  task automatic do_reset();
    rst = 1; cyc(); cyc(); rst = 0;
  endtask

  initial begin
    logic [N-1:0] p, p1, p2, p3;
    logic [127:0] s9;
    s9 = 128'h313233343536373839;
    chk("crc_123456789", crc8(s9, 72), 8'hF4);
    chk("crc_zero", crc8(128'h0, N), 8'h00);
    rst = 1; cyc(); on = 1; cyc(); rst = 0;
    chk("rst_cfg_out", cfg_out, 0);
    chk("rst_ready", bit_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_loaded", cfg_loaded, 0);
    p = 86'h2A_5C3F_0123_4567_89AB_CDEF;
    n_com = 0; n_err = 0;
    frame(p, 0, -1, 0, 0);
    chk("t1_commit_now", cfg_commit, 1);
    cyc();
    chk("t1_commits", n_com, 1);
    chk("t1_cfg", cfg_out, p);
    chk("t1_loaded", cfg_loaded, 1);
    do_reset();
    n_com = 0; n_err = 0;
    frame(p, 1, -1, 0, 0);
    cyc();
    chk("t2_errs", n_err, 1);
    chk("t2_commits", n_com, 0);
    chk("t2_cfg", cfg_out, 0);
    chk("t2_loaded", cfg_loaded, 0);
    do_reset();
    n_com = 0; n_err = 0;
    send_byte(8'h5A, 1); send_byte(8'hA4, 1);
    frame(p, 0, -1, 0, 1);
    cyc();
    chk("t3_commits", n_com, 1);
    chk("t3_cfg", cfg_out, p);
    p1 = {22'($urandom), $urandom, $urandom};
    p2 = {22'($urandom), $urandom, $urandom};
    p3 = {22'($urandom), $urandom, $urandom};
    n_com = 0; n_err = 0;
    frame(p1, 0, -1, 0, 0);
    cyc();
    chk("t4_cfg_p1", cfg_out, p1);
    frame(p2, 0, 40, 0, 0);
    repeat (3) cyc();
    chk("t4_cfg_after_abort", cfg_out, p1);
    frame(p3, 0, -1, 0, 1);
    cyc();
    chk("t4_commits", n_com, 2);
    chk("t4_errs", n_err, 0);
    chk("t4_cfg_p3", cfg_out, p3);
    n_com = 0;
    frame(p1, 0, 60, 1, 0);
    chk("t5_cfg_rst", cfg_out, 0);
    chk("t5_loaded_rst", cfg_loaded, 0);
    frame(p2, 0, -1, 0, 0);
    chk("t5_cfg_before", cfg_out, 0);
    cyc();
    chk("t5_commits", n_com, 1);
    chk("t5_cfg", cfg_out, p2);
    n_com = 0; n_nr = 0;
    frame(p3, 0, -1, 0, 0);
    frame(p1, 0, -1, 0, 0);
    cyc();
    chk("t6_ready_low", n_nr, 2);
    chk("t6_commits", n_com, 2);
    chk("t6_cfg", cfg_out, p1);
    for (int k = 0; k < 4; k++) begin
      p = {22'($urandom), $urandom, $urandom};
      frame(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N-1)) : -1, 0, 1);
      repeat ($urandom_range(0, 3)) cyc();
    end
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish before 500000");
    $fatal(1, "timeout");
  end
endmodule
